// File: rtl/inst_decode_pkg.sv
// mips_defs: opcode/funct encodings, ALU control codes and the decoded control bundle
package mips_defs;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_SLT  = 6'b101010;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b100;
  localparam logic [2:0] ALU_LUI = 3'b101;

  typedef struct packed {
    logic [4:0] rw;
    logic       ext_op;
    logic       alu_src;
    logic [2:0] alu_ctr;
    logic       reg_write;
    logic       mem_to_reg;
    logic       mem_write;
    logic       branch;
    logic       jump;
  } ctrl_t;

endpackage

// File: rtl/inst_decode_reg_file.sv
// reg_file: 2-read 1-write register file, $0 hardwired to zero, write-first bypass
module reg_file #(
  parameter int REG_NUM = 32,
  parameter int DATA_W  = 32,
  localparam int AW = $clog2(REG_NUM)
)(
  input  logic              clk,
  input  logic              reset,
  input  logic [AW-1:0]     ra,
  input  logic [AW-1:0]     rb,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_a,
  output logic [DATA_W-1:0] rd_b
);

  logic [DATA_W-1:0] mem [REG_NUM];
  logic              wr_live;

  assign wr_live = wr_en && wr_addr != '0;

  // reset clears every register and drops a coincident write; $0 is never written
  always_ff @(posedge clk)
    if (reset)
      for (int i = 0; i < REG_NUM; i++) mem[i] <= '0;
    else if (wr_live)
      mem[wr_addr] <= wr_data;

  // bypass beats everything, including reset, so writeback data is visible the same cycle
  always_comb begin
    rd_a = wr_live && wr_addr == ra ? wr_data : (ra == '0 || reset) ? '0 : mem[ra];
    rd_b = wr_live && wr_addr == rb ? wr_data : (rb == '0 || reset) ? '0 : mem[rb];
  end

endmodule

// File: rtl/inst_decode.sv
// inst_decode: single-cycle MIPS decode stage with register file and sticky illegal flag
module inst_decode
  import mips_defs::*;
#(
  parameter int REG_NUM = 32,
  parameter int DATA_W  = 32,
  localparam int AW = $clog2(REG_NUM)
)(
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       Inst,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] busA,
  output logic [DATA_W-1:0] busB,
  output logic [4:0]        rw,
  output logic [15:0]       imm16,
  output logic [25:0]       target,
  output logic              ExtOp,
  output logic              ALUSrc,
  output logic [2:0]        ALUctr,
  output logic              RegWrite,
  output logic              MemtoReg,
  output logic              MemWrite,
  output logic              branch,
  output logic              jump,
  output logic              illegal
);

  logic [5:0] op, funct;
  logic [4:0] rs, rt, rd;
  ctrl_t      ctl;
  logic       legal;

  assign op     = Inst[31:26];
  assign rs     = Inst[25:21];
  assign rt     = Inst[20:16];
  assign rd     = Inst[15:11];
  assign funct  = Inst[5:0];
  assign imm16  = Inst[15:0];
  assign target = Inst[25:0];

  reg_file #(.REG_NUM(REG_NUM), .DATA_W(DATA_W)) u_rf (
    .clk     (clk),
    .reset   (reset),
    .ra      (rs),
    .rb      (rt),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_a    (busA),
    .rd_b    (busB)
  );

  // control decode; anything unrecognised falls through as an all-zero NOP
  always_comb begin
    ctl = '0;
    legal = 1'b1;
    case (op)
      OP_RTYPE: begin
        legal = funct inside {FN_ADDU, FN_SUBU, FN_AND, FN_OR, FN_SLT};
        ctl.alu_ctr = funct == FN_SUBU ? ALU_SUB : funct == FN_AND ? ALU_AND :
                      funct == FN_OR ? ALU_OR : funct == FN_SLT ? ALU_SLT : ALU_ADD;
        ctl.reg_write = legal;
        ctl.rw = legal ? rd : 5'd0;
      end
      OP_ORI, OP_ADDIU, OP_LUI, OP_LW: begin
        ctl.reg_write = 1'b1;
        ctl.alu_src = 1'b1;
        ctl.rw = rt;
        ctl.ext_op = op == OP_ADDIU || op == OP_LW;
        ctl.alu_ctr = op == OP_ORI ? ALU_OR : op == OP_LUI ? ALU_LUI : ALU_ADD;
        ctl.mem_to_reg = op == OP_LW;
      end
      OP_SW: begin
        ctl.ext_op = 1'b1;
        ctl.alu_src = 1'b1;
        ctl.mem_write = 1'b1;
      end
      OP_BEQ: begin
        ctl.branch = 1'b1;
        ctl.ext_op = 1'b1;
        ctl.alu_ctr = ALU_SUB;
      end
      OP_J: ctl.jump = 1'b1;
      default: legal = 1'b0;
    endcase
  end

  assign rw       = ctl.rw;
  assign ExtOp    = ctl.ext_op;
  assign ALUSrc   = ctl.alu_src;
  assign ALUctr   = ctl.alu_ctr;
  assign RegWrite = ctl.reg_write;
  assign MemtoReg = ctl.mem_to_reg;
  assign MemWrite = ctl.mem_write;
  assign branch   = ctl.branch;
  assign jump     = ctl.jump;

  // sticky flag: latches the first undefined instruction until reset
  always_ff @(posedge clk)
    if (reset) illegal <= 1'b0;
    else if (!legal) illegal <= 1'b1;

endmodule
